fetch_stage: RTL and testbench

//  Instruction-fetch stage plus IF/ID pipeline register of the pipelined ARM core.

---
 rtl/fetch_stage_if.sv | 21 ++
 rtl/fetch_stage.sv | 139 +++++++++++++
 tb/tb_fetch_stage.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_stage_if.sv
// rtl/fetch_stage_if.sv - instruction memory req/ack bus between fetch stage and imem
interface fetch_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch with one-outstanding imem request plus IF/ID register
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'hE1A0_0000
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          StallD,
  input  logic          FlushD,
  input  logic          BranchTakenE,
  input  logic [31:0]   ALUResultE,
  input  logic          PCSrcW,
  input  logic [31:0]   ResultW,
  fetch_stage_if.master imem,
  output logic [31:0]   InstrD,
  output logic [31:0]   PCPlus8D,
  output logic          ValidD,
  output logic          FetchBusy
);

  typedef enum logic [1:0] {ST_RST, ST_REQ, ST_HOLD, ST_DROP} state_e;

  state_e      state_q, state_d;
  logic [31:0] pcf_q, pcf_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] buf_q, buf_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc8_q, pc8_d;
  logic        valid_q, valid_d;

  logic        redir;
  logic [31:0] target;
  logic        word_avail;
  logic [31:0] word;
  logic        start_req;

  always_comb begin
    redir      = BranchTakenE | PCSrcW;
    target     = BranchTakenE ? ALUResultE : ResultW;
    state_d    = state_q;
    pcf_d      = pcf_q;
    buf_d      = buf_q;
    word_avail = 1'b0;
    word       = imem.imem_rdata;
    start_req  = 1'b0;

    case (state_q)
      ST_RST: begin
        state_d   = ST_REQ;
        start_req = 1'b1;
      end
      ST_REQ: begin
        word_avail = imem.imem_ack;
        if (imem.imem_ack) begin
          if (redir) begin
            pcf_d     = target;
            start_req = 1'b1;
          end else if (!StallD) begin
            pcf_d     = pcf_q + 32'd4;
            start_req = 1'b1;
          end else begin
            state_d = ST_HOLD;
            buf_d   = imem.imem_rdata;
          end
        end else if (redir) begin
          state_d = ST_DROP;
          pcf_d   = target;
        end
      end
      ST_HOLD: begin
        word_avail = 1'b1;
        word       = buf_q;
        if (redir) begin
          state_d   = ST_REQ;
          pcf_d     = target;
          start_req = 1'b1;
        end else if (!StallD) begin
          state_d   = ST_REQ;
          pcf_d     = pcf_q + 32'd4;
          start_req = 1'b1;
        end
      end
      ST_DROP: begin
        // The stale response must drain before the redirected fetch can issue.
        if (redir) pcf_d = target;
        if (imem.imem_ack) begin
          state_d   = ST_REQ;
          start_req = 1'b1;
        end
      end
      default: state_d = ST_RST;
    endcase

    addr_d = start_req ? pcf_d : addr_q;

    instr_d = instr_q;
    pc8_d   = pc8_q;
    valid_d = valid_q;
    if (!StallD) begin
      if (FlushD || redir || !word_avail) begin
        instr_d = NOP_INSTR;
        pc8_d   = pcf_q + 32'd8;
        valid_d = 1'b0;
      end else begin
        instr_d = word;
        pc8_d   = addr_q + 32'd8;
        valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_RST;
      pcf_q   <= RESET_PC;
      addr_q  <= 32'd0;
      buf_q   <= 32'd0;
      instr_q <= NOP_INSTR;
      pc8_q   <= 32'd0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pcf_q   <= pcf_d;
      addr_q  <= addr_d;
      buf_q   <= buf_d;
      instr_q <= instr_d;
      pc8_q   <= pc8_d;
      valid_q <= valid_d;
    end
  end

  assign imem.imem_req  = (state_q == ST_REQ) || (state_q == ST_DROP);
  assign imem.imem_addr = addr_q;
  assign FetchBusy      = ((state_q == ST_REQ) && !imem.imem_ack) || (state_q == ST_DROP);
  assign InstrD         = instr_q;
  assign PCPlus8D       = pc8_q;
  assign ValidD         = valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed and randomized check of fetch_stage against a transaction model
`timescale 1ns/1ps
module tb_fetch_stage;
  localparam logic [31:0] NOP = 32'hE1A0_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        StallD = 1'b0, FlushD = 1'b0, BranchTakenE = 1'b0, PCSrcW = 1'b0;
  logic [31:0] ALUResultE = 32'd0, ResultW = 32'd0;
  logic [31:0] InstrD, PCPlus8D;
  logic        ValidD, FetchBusy;

  always #5 clk = ~clk;

  fetch_stage_if imem ();

  fetch_stage #(.RESET_PC(32'h0), .NOP_INSTR(NOP)) dut (
    .clk(clk), .reset(reset), .StallD(StallD), .FlushD(FlushD),
    .BranchTakenE(BranchTakenE), .ALUResultE(ALUResultE), .PCSrcW(PCSrcW),
    .ResultW(ResultW), .imem(imem), .InstrD(InstrD), .PCPlus8D(PCPlus8D),
    .ValidD(ValidD), .FetchBusy(FetchBusy)
  );

  int total = 0;
  int bad = 0;

  // model: pc to fetch, outstanding request, discard flag, parked word, IF/ID
  logic [31:0] m_pc, m_addr, m_word, m_instr, m_pc8, key;
  bit          m_rst, m_inflight, m_stale, m_held, m_valid;

  // memory responder
  bit mem_inflight;
  int mem_wait;
  int force_wait = 0;
  bit stray_ack = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'd0; m_addr = 32'd0; m_word = 32'd0;
    m_instr = NOP; m_pc8 = 32'd0; m_valid = 1'b0;
    m_rst = 1'b1; m_inflight = 1'b0; m_stale = 1'b0; m_held = 1'b0;
    mem_inflight = 1'b0; mem_wait = 0;
  endtask

  task automatic model_step(input bit st, fl, bt, pcs, input logic [31:0] alu, resw, input bit ack);
    bit redir, avail;
    logic [31:0] tgt, word;
    redir = bt | pcs;
    tgt = bt ? alu : resw;
    avail = 1'b0;
    word = 32'd0;
    if (!m_rst) begin
      if (m_held) begin avail = 1'b1; word = m_word; end
      else if (m_inflight && !m_stale && ack) begin avail = 1'b1; word = m_addr ^ key; end
    end
    if (!st) begin
      if (fl || redir || !avail) begin m_instr = NOP; m_valid = 1'b0; end
      else begin m_instr = word; m_pc8 = m_addr + 32'd8; m_valid = 1'b1; end
    end
    if (m_rst) begin
      m_rst = 1'b0; m_inflight = 1'b1; m_addr = m_pc;
    end else if (m_stale) begin
      if (redir) m_pc = tgt;
      if (ack) begin m_stale = 1'b0; m_addr = m_pc; end
    end else if (avail) begin
      if (redir || !st) begin
        m_pc = redir ? tgt : m_pc + 32'd4;
        m_held = 1'b0; m_inflight = 1'b1; m_addr = m_pc;
      end else if (!m_held) begin
        m_held = 1'b1; m_word = word; m_inflight = 1'b0;
      end
    end else if (redir) begin
      m_pc = tgt; m_stale = 1'b1;
    end
  endtask

  // called at posedge+1: drive inputs, answer memory, check comb outputs, then registered ones
  task automatic step(input bit st, fl, bt, pcs, input logic [31:0] alu, resw);
    StallD = st; FlushD = fl; BranchTakenE = bt; PCSrcW = pcs;
    ALUResultE = alu; ResultW = resw;
    imem.imem_ack = 1'b0;
    imem.imem_rdata = 32'hDEAD_BEEF;
    if (imem.imem_req) begin
      if (!mem_inflight) begin
        mem_inflight = 1'b1;
        if (force_wait >= 0) mem_wait = force_wait;
        else mem_wait = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
      end
      if (mem_wait == 0) begin
        imem.imem_ack = 1'b1;
        imem.imem_rdata = imem.imem_addr ^ key;
        mem_inflight = 1'b0;
      end else mem_wait--;
    end else if (stray_ack) begin
      imem.imem_ack = 1'b1;
    end
    #4;
    check("imem_req", imem.imem_req, m_inflight);
    if (m_inflight) check("imem_addr", imem.imem_addr, m_addr);
    check("FetchBusy", FetchBusy, m_inflight && (m_stale || !imem.imem_ack));
    model_step(st, fl, bt, pcs, alu, resw, imem.imem_ack);
    @(posedge clk);
    #1;
    check("ValidD", ValidD, m_valid);
    check("InstrD", InstrD, m_instr);
    if (m_valid) check("PCPlus8D", PCPlus8D, m_pc8);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
  endtask

  task automatic run_to(input logic [31:0] a);
    for (int i = 0; i < 64 && m_addr != a; i++) idle();
    check("run_to_addr", imem.imem_addr, a);
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    StallD = 1'b0; FlushD = 1'b0; BranchTakenE = 1'b0; PCSrcW = 1'b0;
    imem.imem_ack = 1'b1;
    imem.imem_rdata = 32'h1234_5678;
    #1;
    check("rst_req", imem.imem_req, 1'b0);
    check("rst_addr", imem.imem_addr, 32'd0);
    check("rst_instr", InstrD, NOP);
    check("rst_pc8", PCPlus8D, 32'd0);
    check("rst_valid", ValidD, 1'b0);
    check("rst_busy", FetchBusy, 1'b0);
    @(posedge clk);
    #1;
    imem.imem_ack = 1'b0;
    reset = 1'b1;
    model_reset();
  endtask

  logic [31:0] rt;

  initial begin
    key = 32'd0;
    imem.imem_ack = 1'b0;
    imem.imem_rdata = 32'd0;
    #2;
    apply_reset();

    // T1: zero-wait memory returning the address
    force_wait = 0;
    repeat (4) idle();
    check("t1_instr", InstrD, 32'd8);
    check("t1_pc8", PCPlus8D, 32'd16);

    // T2: three wait states at 0x10
    run_to(32'h10);
    force_wait = 3;
    idle();
    force_wait = 0;
    repeat (3) idle();
    check("t2_instr", InstrD, 32'h10);
    check("t2_pc8", PCPlus8D, 32'h18);

    // T3: stall while the 0x20 word arrives
    run_to(32'h20);
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    idle();
    check("t3_instr", InstrD, 32'h20);
    check("t3_next", imem.imem_addr, 32'h24);

    // T4: branch during a slow fetch at 0x30
    run_to(32'h30);
    force_wait = 3;
    step(1'b0, 1'b0, 1'b1, 1'b0, 32'h100, 32'd0);
    force_wait = 0;
    repeat (3) idle();
    check("t4_valid", ValidD, 1'b0);
    check("t4_next", imem.imem_addr, 32'h100);

    // T5: execute redirect beats writeback redirect
    step(1'b0, 1'b0, 1'b1, 1'b1, 32'h200, 32'h300);
    check("t5_next", imem.imem_addr, 32'h200);

    // T6: address wrap, then asynchronous reset mid-wait
    step(1'b0, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFC, 32'd0);
    idle();
    check("t6_pc8", PCPlus8D, 32'h4);
    check("t6_next", imem.imem_addr, 32'h0);
    force_wait = 3;
    idle();
    #2;
    apply_reset();
    stray_ack = 1'b1;
    force_wait = 0;
    idle();
    stray_ack = 1'b0;
    idle();
    check("t6_after_rst", InstrD, 32'h0);

    // randomized traffic with scrambled data and random wait states
    key = $urandom;
    force_wait = -1;
    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(0, 7))
        0: rt = 32'hFFFF_FFFC;
        1: rt = $urandom;
        default: rt = $urandom & 32'h0000_0FFC;
      endcase
      step($urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0,
           $urandom_range(0, 11) == 0, $urandom_range(0, 19) == 0,
           rt, $urandom & 32'h0000_FFFC);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
